// File: rtl/bcd_digit_converter.sv
// rtl/bcd_digit_converter.sv - iterative double-dabble binary to BCD converter
// Optional leading-zero blanking mask: define BCD_LEADING_ZERO_BLANK_EN.
module bcd_digit_converter #(
   parameter int INPUT_WIDTH      = 14,
   parameter int NUMBER_OF_DIGITS = 5
) (
   input  logic                          CLK_50,
   input  logic                          resetN,
   input  logic                          start,
   input  logic [INPUT_WIDTH-1:0]        bin_in,
   output logic                          busy,
   output logic                          done,
   output logic [4*NUMBER_OF_DIGITS-1:0] bcd_out,
   output logic                          overflow,
   output logic [NUMBER_OF_DIGITS-1:0]   blank_mask
);

   localparam int BW = 4 * NUMBER_OF_DIGITS;
   localparam int CW = $clog2(INPUT_WIDTH + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                 state_q, state_d;
   logic [INPUT_WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]          work_q, work_d;
   logic                   ovf_work_q, ovf_work_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [BW-1:0]          bcd_q, bcd_d;
   logic                   ovf_q, ovf_d;

   logic [BW-1:0]             adj;
   logic [BW+INPUT_WIDTH-1:0] cat;
   logic [BW+INPUT_WIDTH-1:0] step;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      work_d     = work_q;
      ovf_work_d = ovf_work_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      bcd_d      = bcd_q;
      ovf_d      = ovf_q;

      adj = '0;
      for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
         adj[4*i +: 4] = add3(work_q[4*i +: 4]);
      end
      cat  = {adj, shift_q};
      step = {cat[BW+INPUT_WIDTH-2:0], 1'b0};

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = SHIFT;
               shift_d    = bin_in;
               work_d     = '0;
               ovf_work_d = 1'b0;
               cnt_d      = CW'(INPUT_WIDTH);
               busy_d     = 1'b1;
            end
         end
         SHIFT: begin
            work_d     = step[BW+INPUT_WIDTH-1:INPUT_WIDTH];
            shift_d    = step[INPUT_WIDTH-1:0];
            // a carry out of the top digit means the value needs more digits
            ovf_work_d = ovf_work_q | cat[BW+INPUT_WIDTH-1];
            cnt_d      = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               bcd_d   = work_d;
               ovf_d   = ovf_work_d;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_50 or negedge resetN) begin
      if (!resetN) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         work_q     <= '0;
         ovf_work_q <= 1'b0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         bcd_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         work_q     <= work_d;
         ovf_work_q <= ovf_work_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         bcd_q      <= bcd_d;
         ovf_q      <= ovf_d;
      end
   end

`ifdef BCD_LEADING_ZERO_BLANK_EN
   logic [NUMBER_OF_DIGITS-1:0] blank_q, blank_d;
   logic                        zero_above;

   // digit 0 is never blanked so a zero value still shows one "0"
   always_comb begin
      blank_d    = blank_q;
      zero_above = 1'b1;
      if (done_d) begin
         blank_d = '0;
         for (int i = NUMBER_OF_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (work_d[4*i +: 4] == 4'd0);
            blank_d[i] = zero_above;
         end
      end
   end

   always_ff @(posedge CLK_50 or negedge resetN) begin
      if (!resetN) begin
         blank_q <= '0;
      end else begin
         blank_q <= blank_d;
      end
   end

   assign blank_mask = blank_q;
`else
   assign blank_mask = '0;
`endif

   assign busy     = busy_q;
   assign done     = done_q;
   assign bcd_out  = bcd_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_digit_converter.sv
// tb/tb_bcd_digit_converter.sv - randomized self-checking bench for bcd_digit_converter
module tb_bcd_digit_converter;

   logic        CLK_50 = 1'b0;
   logic        resetN;
   logic        start;
   logic [13:0] bin_in;
   logic        busy, done, overflow;
   logic [19:0] bcd_out;
   logic [4:0]  blank_mask;
   logic        d4_busy, d4_done, d4_overflow;
   logic [15:0] d4_bcd_out;
   logic [3:0]  d4_blank_mask;

   int total = 0;
   int bad   = 0;

   always #10 CLK_50 = ~CLK_50;

   bcd_digit_converter #(.INPUT_WIDTH(14), .NUMBER_OF_DIGITS(5)) dut (
      .CLK_50(CLK_50), .resetN(resetN), .start(start), .bin_in(bin_in),
      .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow),
      .blank_mask(blank_mask)
   );

   bcd_digit_converter #(.INPUT_WIDTH(14), .NUMBER_OF_DIGITS(4)) dut4 (
      .CLK_50(CLK_50), .resetN(resetN), .start(start), .bin_in(bin_in),
      .busy(d4_busy), .done(d4_done), .bcd_out(d4_bcd_out), .overflow(d4_overflow),
      .blank_mask(d4_blank_mask)
   );

   function automatic int pow10(int n);
      int p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   function automatic logic [31:0] m_bcd(int v, int nd);
      logic [31:0] r = '0;
      for (int i = 0; i < nd; i++) r = r | (32'((v / pow10(i)) % 10) << (4 * i));
      return r;
   endfunction

   function automatic logic m_ovf(int v, int nd);
      return v >= pow10(nd);
   endfunction

   function automatic logic [7:0] m_blank(int v, int nd);
      logic [7:0] r = '0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      for (int i = 1; i < nd; i++) r[i] = (((v % pow10(nd)) / pow10(i)) == 0);
`endif
      return r;
   endfunction

   // drives one start and measures accept-to-done latency and busy length
   task automatic do_conv(input int v, output int lat, output int busy_cnt);
      bin_in = 14'(v);
      start  = 1'b1;
      @(posedge CLK_50);
      @(negedge CLK_50);
      start    = 1'b0;
      bin_in   = 14'($urandom);
      lat      = 0;
      busy_cnt = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         @(negedge CLK_50);
         lat++;
      end
   endtask

   task automatic test_reset();
      int lat, bc;
      logic [19:0] e;
      total++;
      if ({busy, done, bcd_out, overflow, blank_mask} !== 28'd0) begin
         bad++; $display("FAIL reset_values got %h want 0", {busy, done, bcd_out, overflow, blank_mask});
      end
      do_conv(9999, lat, bc);
      @(negedge CLK_50);
      bin_in = 14'd777; start = 1'b1;
      @(posedge CLK_50);
      @(negedge CLK_50);
      start = 1'b0;
      repeat (5) @(negedge CLK_50);
      resetN = 1'b0;
      #1;
      total++;
      if ({busy, done, bcd_out, overflow, blank_mask} !== 28'd0) begin
         bad++; $display("FAIL reset_mid_shift got %h want 0", {busy, done, bcd_out, overflow, blank_mask});
      end
      @(negedge CLK_50);
      resetN = 1'b1;
      repeat (20) @(negedge CLK_50);
      total++;
      if (bcd_out !== 20'd0 || done !== 1'b0) begin
         bad++; $display("FAIL reset_discard got bcd=%h done=%b want 0", bcd_out, done);
      end
      do_conv(4321, lat, bc);
      e = 20'(m_bcd(4321, 5));
      total++;
      if (bcd_out !== e || lat != 14) begin
         bad++; $display("FAIL reset_recover got %h lat=%0d want %h lat=14", bcd_out, lat, e);
      end
      @(negedge CLK_50);
   endtask

   task automatic test_basic();
      int lat, bc;
      do_conv(12345, lat, bc);
      total++;
      if (lat != 14) begin bad++; $display("FAIL basic_latency got %0d want 14", lat); end
      total++;
      if (bc != 14) begin bad++; $display("FAIL basic_busy_len got %0d want 14", bc); end
      total++;
      if (bcd_out !== 20'h12345 || overflow !== 1'b0) begin
         bad++; $display("FAIL basic_value got %h ovf=%b want 12345 ovf=0", bcd_out, overflow);
      end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
      @(negedge CLK_50);
      total++;
      if (done !== 1'b0 || bcd_out !== 20'h12345) begin
         bad++; $display("FAIL basic_done_pulse got done=%b bcd=%h want 0 12345", done, bcd_out);
      end
   endtask

   task automatic test_limits();
      int lat, bc;
      do_conv(0, lat, bc);
      total++;
      if (bcd_out !== 20'h0 || overflow !== 1'b0 || blank_mask !== 5'(m_blank(0, 5))) begin
         bad++; $display("FAIL limit_zero got %h ovf=%b blank=%b", bcd_out, overflow, blank_mask);
      end
      @(negedge CLK_50);
      do_conv(16383, lat, bc);
      total++;
      if (bcd_out !== 20'h16383 || overflow !== 1'b0 || blank_mask !== 5'(m_blank(16383, 5))) begin
         bad++; $display("FAIL limit_max got %h ovf=%b blank=%b", bcd_out, overflow, blank_mask);
      end
      @(negedge CLK_50);
   endtask

   task automatic test_overflow();
      int lat, bc;
      do_conv(12345, lat, bc);
      total++;
      if (d4_bcd_out !== 16'h2345 || d4_overflow !== 1'b1) begin
         bad++; $display("FAIL ovf_set got %h ovf=%b want 2345 ovf=1", d4_bcd_out, d4_overflow);
      end
      @(negedge CLK_50);
      do_conv(42, lat, bc);
      total++;
      if (d4_bcd_out !== 16'h0042 || d4_overflow !== 1'b0) begin
         bad++; $display("FAIL ovf_clear got %h ovf=%b want 0042 ovf=0", d4_bcd_out, d4_overflow);
      end
      total++;
      if (blank_mask !== 5'(m_blank(42, 5))) begin
         bad++; $display("FAIL blank_42 got %b want %b", blank_mask, 5'(m_blank(42, 5)));
      end
      @(negedge CLK_50);
   endtask

   task automatic test_ignore_start();
      int v1, v2, ndone;
      logic [19:0] e;
      v1 = $urandom_range(0, 16383);
      v2 = $urandom_range(0, 16383);
      bin_in = 14'(v1); start = 1'b1;
      @(posedge CLK_50);
      @(negedge CLK_50);
      start = 1'b0;
      repeat (4) @(negedge CLK_50);
      bin_in = 14'(v2); start = 1'b1;
      @(negedge CLK_50);
      start = 1'b0;
      ndone = 0;
      e = 20'(m_bcd(v1, 5));
      for (int i = 0; i < 30; i++) begin
         if (done) begin
            ndone++;
            total++;
            if (bcd_out !== e) begin
               bad++; $display("FAIL ignore_value got %h want %h", bcd_out, e);
            end
         end
         @(negedge CLK_50);
      end
      total++;
      if (ndone != 1) begin bad++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
   endtask

   task automatic test_back_to_back();
      int base, ndone, v;
      logic [19:0] e;
      base  = $urandom_range(0, 16383 - 100);
      ndone = 0;
      for (int s = 0; s <= 76; s++) begin
         if (done) begin
            v = base + 15 * ndone;
            ndone++;
            e = 20'(m_bcd(v, 5));
            total++;
            if (s != 15 * ndone || bcd_out !== e) begin
               bad++; $display("FAIL b2b_done%0d got s=%0d bcd=%h want s=%0d bcd=%h", ndone, s, bcd_out, 15 * ndone, e);
            end
         end
         bin_in = 14'(base + s);
         start  = 1'b1;
         @(negedge CLK_50);
      end
      start = 1'b0;
      repeat (20) @(negedge CLK_50);
      total++;
      if (ndone != 5) begin bad++; $display("FAIL b2b_count got %0d want 5", ndone); end
   endtask

   task automatic test_random();
      int v, lat, bc;
      logic [19:0] e5;
      logic [15:0] e4;
      for (int n = 0; n < 20; n++) begin
         v = (n < 10) ? $urandom_range(0, 16383) : $urandom_range(0, 120);
         do_conv(v, lat, bc);
         e5 = 20'(m_bcd(v, 5));
         e4 = 16'(m_bcd(v, 4));
         total++;
         if (lat != 14 || bcd_out !== e5 || overflow !== m_ovf(v, 5) || blank_mask !== 5'(m_blank(v, 5))) begin
            bad++; $display("FAIL rand5 v=%0d got lat=%0d %h ovf=%b blank=%b want %h", v, lat, bcd_out, overflow, blank_mask, e5);
         end
         total++;
         if (d4_bcd_out !== e4 || d4_overflow !== m_ovf(v, 4) || d4_blank_mask !== 4'(m_blank(v, 4))) begin
            bad++; $display("FAIL rand4 v=%0d got %h ovf=%b blank=%b want %h ovf=%b", v, d4_bcd_out, d4_overflow, d4_blank_mask, e4, m_ovf(v, 4));
         end
         @(negedge CLK_50);
      end
   endtask

   initial begin
      resetN = 1'b0;
      start  = 1'b0;
      bin_in = '0;
      repeat (3) @(negedge CLK_50);
      test_reset();
      resetN = 1'b0;
      @(negedge CLK_50);
      test_reset();
      test_basic();
      test_limits();
      test_overflow();
      test_ignore_start();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
